// File: rtl/mem_data_ctrl.sv
// Data-memory controller for the load/store unit: a single-port synchronous
// RAM serving a load channel and a posted-store channel. Stores are held in a
// FIFO write buffer and drained whenever no legal load needs the RAM port.
module mem_data_ctrl #(
  parameter int XLEN       = 32,
  parameter int ADDR_W     = 10,
  parameter int WBUF_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [XLEN-1:0] ld_addr,
  input  logic [1:0]      ld_size,
  input  logic            ld_unsigned,
  output logic            ld_rvalid,
  output logic [XLEN-1:0] ld_rdata,
  output logic            ld_misalign,
  input  logic            st_valid,
  output logic            st_ready,
  input  logic [XLEN-1:0] st_addr,
  input  logic [1:0]      st_size,
  input  logic [XLEN-1:0] st_data,
  output logic            st_misalign,
  output logic            wbuf_empty
);

  localparam int NB        = XLEN / 8;
  localparam int B         = $clog2(NB);
  localparam int IDX_W     = $clog2(WBUF_DEPTH);
  localparam int PTR_W     = IDX_W + 1;
  localparam int RAM_DEPTH = 1 << ADDR_W;

  // Alignment rule shared by both channels; doubles only exist on 64-bit builds.
  function automatic logic is_legal(input logic [2:0] low, input logic [1:0] size);
    case (size)
      2'b00:   return 1'b1;
      2'b01:   return !low[0];
      2'b10:   return low[1:0] == 2'b00;
      default: return (XLEN == 64) && (low == 3'b000);
    endcase
  endfunction

  // Byte-enable pattern for an access of the given size, before lane shift.
  function automatic logic [NB-1:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   return NB'(1);
      2'b01:   return NB'(3);
      2'b10:   return NB'(15);
      default: return '1;
    endcase
  endfunction

  logic [XLEN-1:0]   ram_q [RAM_DEPTH];
  logic [XLEN-1:0]   ram_rdata_q;

  logic [ADDR_W-1:0] buf_widx_q [WBUF_DEPTH];
  logic [XLEN-1:0]   buf_data_q [WBUF_DEPTH];
  logic [NB-1:0]     buf_be_q   [WBUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
  logic [IDX_W-1:0]  head_idx, tail_idx;
  logic              buf_full, buf_empty, hit;
  logic [WBUF_DEPTH-1:0] entry_hit;

  logic [ADDR_W-1:0] ld_widx, st_widx;
  logic [B-1:0]      ld_lane, st_lane;
  logic              ld_acc, ld_legal, ld_go, st_acc, st_legal, push, pop;
  logic [XLEN-1:0]   st_data_sh;
  logic [NB-1:0]     st_be;

  logic              ld_rvalid_q, ld_mis_q, st_mis_q, rsp_unsigned_q;
  logic [1:0]        rsp_size_q;
  logic [B-1:0]      rsp_lane_q;
  logic [XLEN-1:0]   rsp_shifted, rsp_mask, rsp_ext;
  logic              rsp_sign;

  // Address bits above the RAM index are ignored, so addresses alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ld_addr[XLEN-1:ADDR_W+B], st_addr[XLEN-1:ADDR_W+B]};

  assign ld_widx = ld_addr[ADDR_W+B-1:B];
  assign st_widx = st_addr[ADDR_W+B-1:B];
  assign ld_lane = ld_addr[B-1:0];
  assign st_lane = st_addr[B-1:0];

  assign count     = wr_ptr_q - rd_ptr_q;
  assign head_idx  = rd_ptr_q[IDX_W-1:0];
  assign tail_idx  = wr_ptr_q[IDX_W-1:0];
  assign buf_empty = (wr_ptr_q == rd_ptr_q);
  assign buf_full  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                     (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);

  // An entry is live when its distance from the head is below the occupancy.
  for (genvar gi = 0; gi < WBUF_DEPTH; gi++) begin : g_hit
    logic [IDX_W-1:0] rel;
    assign rel           = IDX_W'(gi) - head_idx;
    assign entry_hit[gi] = ({1'b0, rel} < count) && (buf_widx_q[gi] == ld_widx);
  end
  assign hit = |entry_hit;

  assign ld_ready = !buf_full && !hit;
  assign st_ready = !buf_full;

  assign ld_acc   = ld_valid && ld_ready;
  assign ld_legal = is_legal(ld_addr[2:0], ld_size);
  assign ld_go    = ld_acc && ld_legal;
  assign st_acc   = st_valid && st_ready;
  assign st_legal = is_legal(st_addr[2:0], st_size);
  assign push     = st_acc && st_legal;
  // A legal load owns the RAM port; otherwise the head store drains.
  assign pop      = !ld_go && !buf_empty;

  assign st_data_sh = st_data << {st_lane, 3'b000};
  assign st_be      = size_mask(st_size) << st_lane;

  assign wr_ptr_d = wr_ptr_q + PTR_W'(push);
  assign rd_ptr_d = rd_ptr_q + PTR_W'(pop);

  // Buffer pointers; reset discards every pending store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Buffer payload written at the tail on a legal accepted store.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_widx_q[tail_idx] <= st_widx;
      buf_data_q[tail_idx] <= st_data_sh;
      buf_be_q[tail_idx]   <= st_be;
    end
  end

  // Single RAM port: load read has priority, else byte-enabled head drain.
  always_ff @(posedge clk) begin
    if (ld_go) begin
      ram_rdata_q <= ram_q[ld_widx];
    end else if (pop) begin
      for (int i = 0; i < NB; i++) begin
        if (buf_be_q[head_idx][i]) begin
          ram_q[buf_widx_q[head_idx]][i*8 +: 8] <= buf_data_q[head_idx][i*8 +: 8];
        end
      end
    end
  end

  // Response bookkeeping for the load issued in the previous cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_rvalid_q    <= 1'b0;
      ld_mis_q       <= 1'b0;
      st_mis_q       <= 1'b0;
      rsp_unsigned_q <= 1'b0;
      rsp_size_q     <= 2'b00;
      rsp_lane_q     <= '0;
    end else begin
      ld_rvalid_q <= ld_acc;
      ld_mis_q    <= ld_acc && !ld_legal;
      st_mis_q    <= st_acc && !st_legal;
      if (ld_acc) begin
        rsp_unsigned_q <= ld_unsigned;
        rsp_size_q     <= ld_size;
        rsp_lane_q     <= ld_lane;
      end
    end
  end

  // Lane select and sign/zero extension of the RAM read word.
  always_comb begin
    rsp_shifted = ram_rdata_q >> {rsp_lane_q, 3'b000};
    rsp_mask    = '1;
    rsp_sign    = rsp_shifted[XLEN-1];
    case (rsp_size_q)
      2'b00: begin rsp_mask = XLEN'(8'hFF);         rsp_sign = rsp_shifted[7];  end
      2'b01: begin rsp_mask = XLEN'(16'hFFFF);      rsp_sign = rsp_shifted[15]; end
      2'b10: begin rsp_mask = XLEN'(32'hFFFF_FFFF); rsp_sign = rsp_shifted[31]; end
      default: ;
    endcase
    rsp_ext = (rsp_shifted & rsp_mask) |
              ((rsp_sign && !rsp_unsigned_q) ? ~rsp_mask : '0);
  end

  assign ld_rvalid   = ld_rvalid_q;
  assign ld_misalign = ld_mis_q;
  assign ld_rdata    = (ld_rvalid_q && !ld_mis_q) ? rsp_ext : '0;
  assign st_misalign = st_mis_q;
  assign wbuf_empty  = buf_empty;

endmodule

// File: tb/tb_mem_data_ctrl.sv
// Self-checking bench for mem_data_ctrl: table of directed transactions,
// hand-written multi-cycle sequences, and random traffic checked against a
// byte-addressed memory model that sees each store at the moment it is accepted.
module tb_mem_data_ctrl;
  localparam int XLEN = 32;
  localparam int ADDR_W = 10;
  localparam int WBUF_DEPTH = 4;
  localparam int MEM_BYTES = 4 << ADDR_W;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ld_valid = 1'b0, ld_unsigned = 1'b0, st_valid = 1'b0;
  logic [31:0] ld_addr = '0, st_addr = '0, st_data = '0;
  logic [1:0]  ld_size = '0, st_size = '0;
  logic        ld_ready, ld_rvalid, ld_misalign, st_ready, st_misalign, wbuf_empty;
  logic [31:0] ld_rdata;

  always #5 clk = ~clk;

  mem_data_ctrl #(.XLEN(XLEN), .ADDR_W(ADDR_W), .WBUF_DEPTH(WBUF_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_size(ld_size),
    .ld_unsigned(ld_unsigned), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .ld_misalign(ld_misalign), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_size(st_size), .st_data(st_data),
    .st_misalign(st_misalign), .wbuf_empty(wbuf_empty)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  bit          verbose = 1'b0;
  logic [7:0]  mm [MEM_BYTES];
  logic [31:0] last_rdata;
  logic        last_mis;
  bit          lrdy_seen, srdy_seen;

  typedef struct {
    bit          is_st;
    logic [31:0] addr;
    logic [1:0]  size;
    bit          uns;
    logic [31:0] data;
    logic [31:0] exp_d;
    bit          exp_mis;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic bit legal(input logic [31:0] a, input logic [1:0] sz);
    case (sz)
      2'd0:    return 1'b1;
      2'd1:    return a[0] == 1'b0;
      2'd2:    return a[1:0] == 2'b00;
      default: return (XLEN == 64) && (a[2:0] == 3'b000);
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input bit u);
    int n = 1 << sz;
    int base = int'(a[ADDR_W+1:0]);
    logic [31:0] v = '0;
    for (int j = 0; j < n; j++) v |= 32'(mm[base+j]) << (8*j);
    if (!u && n < 4 && v[8*n-1]) v |= ~((32'h1 << (8*n)) - 32'h1);
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    int n = 1 << sz;
    int base = int'(a[ADDR_W+1:0]);
    for (int j = 0; j < n; j++) mm[base+j] = d[8*j +: 8];
  endtask

  // One clock cycle: drive at the falling edge, resolve handshakes, update
  // the model, then check the registered outputs at the next falling edge.
  task automatic cycle(input bit lv, input logic [31:0] la, input logic [1:0] lsz, input bit lu,
                       input bit sv, input logic [31:0] sa, input logic [1:0] ssz,
                       input logic [31:0] sd, output bit l_acc, output bit s_acc);
    logic [31:0] exp_d;
    bit exp_mis, exp_smis;
    ld_valid = lv; ld_addr = la; ld_size = lsz; ld_unsigned = lu;
    st_valid = sv; st_addr = sa; st_size = ssz; st_data = sd;
    #1;
    lrdy_seen = ld_ready;
    srdy_seen = st_ready;
    l_acc = lv && ld_ready;
    s_acc = sv && st_ready;
    exp_mis = !legal(la, lsz);
    exp_d = exp_mis ? 32'h0 : model_load(la, lsz, lu);
    exp_smis = s_acc && !legal(sa, ssz);
    if (s_acc && legal(sa, ssz)) model_store(sa, ssz, sd);
    @(negedge clk);
    check("ld_rvalid", ld_rvalid, l_acc);
    if (l_acc) begin
      check("ld_misalign", ld_misalign, exp_mis);
      check("ld_rdata", ld_rdata, exp_d);
      last_rdata = ld_rdata;
      last_mis = ld_misalign;
      if (verbose) $display("LD addr=%08h size=%0d uns=%0d -> rdata=%08h misalign=%0b",
                            la, lsz, lu, ld_rdata, ld_misalign);
    end
    check("st_misalign", st_misalign, exp_smis);
    if (verbose && s_acc) $display("ST addr=%08h size=%0d data=%08h misalign=%0b",
                                   sa, ssz, sd, exp_smis);
  endtask

  task automatic idle();
    bit a, b;
    cycle(0, 0, 0, 0, 0, 0, 0, 0, a, b);
  endtask

  task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input bit u,
                         output logic [31:0] d, output logic mis);
    bit la, sa;
    la = 0;
    for (int t = 0; t < 50 && !la; t++) cycle(1, a, sz, u, 0, 0, 0, 0, la, sa);
    check("ld_accept", la, 1);
    d = last_rdata;
    mis = last_mis;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    bit la, sa;
    sa = 0;
    for (int t = 0; t < 50 && !sa; t++) cycle(0, 0, 0, 0, 1, a, sz, d, la, sa);
    check("st_accept", sa, 1);
  endtask

  task automatic wait_drain(input string name);
    for (int t = 0; t < 20 && !wbuf_empty; t++) idle();
    check(name, wbuf_empty, 1);
  endtask

  task automatic add_vec(input bit is_st, input logic [31:0] a, input logic [1:0] sz, input bit u,
                         input logic [31:0] d, input logic [31:0] ed, input bit em);
    vec_t v;
    v.is_st = is_st; v.addr = a; v.size = sz; v.uns = u;
    v.data = d; v.exp_d = ed; v.exp_mis = em;
    tbl.push_back(v);
  endtask

  // Continuous loads to an unrelated word while six stores are pushed.
  task automatic test_fill();
    logic [31:0] sa_l [6];
    logic [1:0]  ss_l [6];
    logic [31:0] sd_l [6];
    logic [31:0] d;
    logic        m;
    bit la, sa, saw_st_stall, saw_ld_stall;
    int k;
    sa_l[0] = 32'h70; ss_l[0] = 2; sd_l[0] = 32'hAAAA0001;
    sa_l[1] = 32'h74; ss_l[1] = 2; sd_l[1] = 32'hBBBB0002;
    sa_l[2] = 32'h72; ss_l[2] = 0; sd_l[2] = 32'h000000CC;
    sa_l[3] = 32'h7A; ss_l[3] = 1; sd_l[3] = 32'h0000DDDD;
    sa_l[4] = 32'h74; ss_l[4] = 2; sd_l[4] = 32'hEEEE0005;
    sa_l[5] = 32'h7C; ss_l[5] = 2; sd_l[5] = 32'hFFFF0006;
    k = 0; saw_st_stall = 0; saw_ld_stall = 0;
    for (int c = 0; c < 100 && k < 6; c++) begin
      cycle(1, 32'h60 | 32'(c % 4), 0, c[0], 1, sa_l[k], ss_l[k], sd_l[k], la, sa);
      if (!srdy_seen) saw_st_stall = 1;
      if (!srdy_seen && !lrdy_seen) saw_ld_stall = 1;
      if (sa) k++;
    end
    check("fill_all_pushed", k, 6);
    check("fill_st_ready_drop", saw_st_stall, 1);
    check("fill_ld_ready_drop", saw_ld_stall, 1);
    wait_drain("fill_drained");
    do_load(32'h70, 2, 0, d, m); check("fifo_w70", d, 32'hAACC0001);
    do_load(32'h74, 2, 0, d, m); check("fifo_w74", d, 32'hEEEE0005);
    do_load(32'h78, 2, 0, d, m); check("fifo_w78", d, 32'hDDDD561E);
    do_load(32'h7C, 2, 0, d, m); check("fifo_w7c", d, 32'hFFFF0006);
  endtask

  // Reset asserted while two stores are still buffered.
  task automatic test_reset_mid_drain();
    logic [31:0] d;
    logic        m;
    bit la, sa;
    cycle(1, 32'h60, 2, 0, 1, 32'h100, 2, 32'h77770000, la, sa); check("rst_push0", sa, 1);
    cycle(1, 32'h64, 2, 0, 1, 32'h104, 2, 32'h88880000, la, sa); check("rst_push1", sa, 1);
    cycle(1, 32'h68, 2, 0, 1, 32'h108, 2, 32'h99990000, la, sa); check("rst_push2", sa, 1);
    idle();
    check("rst_wbuf_busy", wbuf_empty, 0);
    cycle(1, 32'h6C, 2, 0, 1, 32'h103, 2, 32'h0, la, sa);
    ld_valid = 0; st_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_wbuf_empty", wbuf_empty, 1);
    check("rst_ld_rvalid", ld_rvalid, 0);
    check("rst_ld_rdata", ld_rdata, 0);
    check("rst_ld_misalign", ld_misalign, 0);
    check("rst_st_misalign", st_misalign, 0);
    model_store(32'h104, 2, 32'h12345641);
    model_store(32'h108, 2, 32'h12345642);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_wbuf_after", wbuf_empty, 1);
    do_load(32'h100, 2, 0, d, m); check("rst_drained_w100", d, 32'h77770000);
    do_load(32'h104, 2, 0, d, m); check("rst_dropped_w104", d, 32'h12345641);
    do_load(32'h108, 2, 0, d, m); check("rst_dropped_w108", d, 32'h12345642);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, la, sa, r;
    logic        m;
    bit          lacc, sacc;

    for (int i = 0; i < MEM_BYTES; i++) mm[i] = 8'h00;

    #1 rst_n = 1'b0;
    #2;
    check("reset_wbuf_empty", wbuf_empty, 1);
    check("reset_ld_rvalid", ld_rvalid, 0);
    check("reset_ld_rdata", ld_rdata, 0);
    check("reset_ld_misalign", ld_misalign, 0);
    check("reset_st_misalign", st_misalign, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 128; i++) do_store(32'(i * 4), 2, 32'h12345600 | 32'(i));
    wait_drain("prefill_drained");
    verbose = 1'b1;

    add_vec(1, 32'h10, 2, 0, 32'hDEADBEEF, 0, 0);
    add_vec(0, 32'h10, 2, 0, 0, 32'hDEADBEEF, 0);
    add_vec(1, 32'h21, 0, 0, 32'h12345680, 0, 0);
    add_vec(0, 32'h21, 0, 0, 0, 32'hFFFFFF80, 0);
    add_vec(0, 32'h21, 0, 1, 0, 32'h00000080, 0);
    add_vec(0, 32'h20, 2, 0, 0, 32'h12348008, 0);
    add_vec(0, 32'h22, 1, 0, 0, 32'h00001234, 0);
    add_vec(1, 32'h46, 1, 0, 32'h0000BEEF, 0, 0);
    add_vec(0, 32'h46, 1, 0, 0, 32'hFFFFBEEF, 0);
    add_vec(0, 32'h46, 1, 1, 0, 32'h0000BEEF, 0);
    add_vec(0, 32'hFFFFF044, 2, 0, 0, 32'hBEEF5611, 0);
    add_vec(0, 32'h47, 0, 0, 0, 32'hFFFFFFBE, 0);
    add_vec(0, 32'h03, 1, 0, 0, 32'h0, 1);
    add_vec(0, 32'h06, 2, 0, 0, 32'h0, 1);
    add_vec(0, 32'h08, 3, 0, 0, 32'h0, 1);
    add_vec(1, 32'h06, 2, 0, 32'h55555555, 0, 0);
    add_vec(0, 32'h04, 2, 0, 0, 32'h12345601, 0);
    add_vec(1, 32'h08, 3, 0, 32'h66666666, 0, 0);
    add_vec(0, 32'h08, 2, 0, 0, 32'h12345602, 0);
    add_vec(0, 32'h0D, 0, 1, 0, 32'h00000056, 0);
    add_vec(0, 32'h0E, 1, 0, 0, 32'h00001234, 0);

    foreach (tbl[i]) begin
      if (tbl[i].is_st) begin
        do_store(tbl[i].addr, tbl[i].size, tbl[i].data);
      end else begin
        do_load(tbl[i].addr, tbl[i].size, tbl[i].uns, d, m);
        check($sformatf("tbl%0d_rdata", i), d, tbl[i].exp_d);
        check($sformatf("tbl%0d_misalign", i), m, tbl[i].exp_mis);
      end
    end

    // Load right behind a store to the same word must wait for the drain.
    do_store(32'h40, 2, 32'h11111111);
    check("hit_wbuf_busy", wbuf_empty, 0);
    cycle(1, 32'h40, 2, 0, 0, 0, 0, 0, lacc, sacc);
    check("hit_ld_ready_low", lrdy_seen, 0);
    do_load(32'h40, 2, 0, d, m);
    check("hit_rdata", d, 32'h11111111);
    check("hit_wbuf_empty", wbuf_empty, 1);

    test_fill();

    for (int c = 0; c < 400; c++) begin
      r = $urandom();
      la = (r & 32'hFFFFF000) | 32'($urandom_range(0, 127));
      r = $urandom();
      sa = (r & 32'hFFFFF000) | 32'($urandom_range(0, 127));
      cycle($urandom_range(0, 9) < 6, la, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 9) < 6, sa, 2'($urandom_range(0, 3)), $urandom(), lacc, sacc);
    end
    wait_drain("random_drained");

    test_reset_mid_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
